// File: rtl/operand_stage.sv
// Decode/operand stage ahead of the ALU: decodes one RV32 instruction per handshake,
// reads the register file with write-back bypass and holds the result in a one-entry buffer.
module operand_stage #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      alu_opc,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal
);

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_FULL   = 1'b1;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic [0:0]      state_r;
    logic [0:0]      state_nxt_s;
    logic [XLEN-1:0] regs_r [0:31];
    logic [4:0]      opc_r;
    logic [XLEN-1:0] op1_r;
    logic [XLEN-1:0] op2_r;
    logic [4:0]      rd_r;
    logic            we_r;
    logic            illegal_r;

    logic            wb_wr_s;
    logic            accept_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    logic [2:0]      f3_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic [4:0]      dec_opc_s;
    logic [XLEN-1:0] dec_op1_s;
    logic [XLEN-1:0] dec_op2_s;
    logic            dec_we_s;
    logic            dec_illegal_s;

    // x0 reads as zero; a same-cycle write-back wins over the stored value
    function automatic logic [XLEN-1:0] bypass_read(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_val,
        input logic            wr_en,
        input logic [4:0]      wr_idx,
        input logic [XLEN-1:0] wr_data
    );
        if (idx == 5'd0) begin
            return {XLEN{1'b0}};
        end else if (wr_en && (wr_idx == idx)) begin
            return wr_data;
        end else begin
            return rf_val;
        end
    endfunction

    assign wb_wr_s   = wb_en & (wb_rd != 5'd0);
    assign rs1_s     = instr[19:15];
    assign rs2_s     = instr[24:20];
    assign rd_s      = instr[11:7];
    assign f3_s      = instr[14:12];
    assign rs1_val_s = bypass_read(rs1_s, regs_r[rs1_s], wb_wr_s, wb_rd, wb_data);
    assign rs2_val_s = bypass_read(rs2_s, regs_r[rs2_s], wb_wr_s, wb_rd, wb_data);

    assign in_ready  = (state_r == ST_EMPTY) | out_ready;
    assign accept_s  = in_valid & in_ready & ~flush;

    assign out_valid   = (state_r == ST_FULL);
    assign alu_opc     = opc_r;
    assign alu_op1     = op1_r;
    assign alu_op2     = op2_r;
    assign out_rd      = rd_r;
    assign out_we      = we_r;
    assign out_illegal = illegal_r;

    // Instruction decode into ALU operation code and operands
    always_comb begin
        dec_opc_s     = 5'b00000;
        dec_op1_s     = {XLEN{1'b0}};
        dec_op2_s     = {XLEN{1'b0}};
        dec_we_s      = 1'b0;
        dec_illegal_s = 1'b0;
        case (instr[6:0])
            OPC_R: begin
                dec_opc_s = {instr[30], instr[25], f3_s};
                dec_op1_s = rs1_val_s;
                dec_op2_s = rs2_val_s;
                dec_we_s  = 1'b1;
            end
            OPC_I: begin
                dec_opc_s = {2'b00, f3_s};
                dec_op1_s = rs1_val_s;
                // shift-left immediates carry only the 5-bit shamt
                if (f3_s == 3'b001) begin
                    dec_op2_s = {{(XLEN-5){1'b0}}, instr[24:20]};
                end else begin
                    dec_op2_s = {{(XLEN-12){instr[31]}}, instr[31:20]};
                end
                dec_we_s  = 1'b1;
            end
            OPC_LUI: begin
                dec_op2_s = {instr[31:12], 12'h000};
                dec_we_s  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op1_s = pc;
                dec_op2_s = {instr[31:12], 12'h000};
                dec_we_s  = 1'b1;
            end
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // Buffer occupancy: flush always empties, a stall holds, otherwise follow in_valid
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (flush) begin
                    state_nxt_s = ST_EMPTY;
                end else if (in_valid) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    state_nxt_s = ST_EMPTY;
                end else if (!out_ready) begin
                    state_nxt_s = ST_FULL;
                end else if (in_valid) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Output buffer; contents change only on an accepted instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_EMPTY;
            opc_r     <= 5'b00000;
            op1_r     <= RESET_PC[XLEN-1:0];
            op2_r     <= {XLEN{1'b0}};
            rd_r      <= 5'd0;
            we_r      <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                opc_r     <= dec_opc_s;
                op1_r     <= dec_op1_s;
                op2_r     <= dec_op2_s;
                rd_r      <= rd_s;
                we_r      <= dec_we_s & (rd_s != 5'd0);
                illegal_r <= dec_illegal_s;
            end else begin
                opc_r     <= opc_r;
                op1_r     <= op1_r;
                op2_r     <= op2_r;
                rd_r      <= rd_r;
                we_r      <= we_r;
                illegal_r <= illegal_r;
            end
        end
    end

    // Register file write port; entry 0 is never written and stays zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_wr_s) begin
            regs_r[wb_rd] <= wb_data;
        end else begin
            regs_r[wb_rd] <= regs_r[wb_rd];
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios then random traffic, all checked against
// an architectural model of the register file and the one-entry output buffer.
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, wb_en, out_ready;
    logic [31:0] instr, pc, wb_data;
    logic [4:0]  wb_rd;
    logic        in_ready, out_valid, out_we, out_illegal;
    logic [4:0]  alu_opc, out_rd;
    logic [31:0] alu_op1, alu_op2;

    always #5 clk = ~clk;

    operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_opc(alu_opc), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    // architectural model
    logic [31:0] m_rf [32];
    logic        m_valid, m_we, m_ill;
    logic [4:0]  m_opc, m_rd;
    logic [31:0] m_op1, m_op2;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_value(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_rd == idx) return wb_data;
        return m_rf[idx];
    endfunction

    task automatic model_load();
        int imm;
        m_rd  = instr[11:7];
        m_opc = 5'd0;
        m_op1 = 32'd0;
        m_op2 = 32'd0;
        m_we  = 1'b1;
        m_ill = 1'b0;
        imm   = $signed(instr[31:20]);
        case (instr[6:0])
            7'h33: begin
                m_opc = {instr[30], instr[25], instr[14:12]};
                m_op1 = reg_value(instr[19:15]);
                m_op2 = reg_value(instr[24:20]);
            end
            7'h13: begin
                m_opc = {2'b00, instr[14:12]};
                m_op1 = reg_value(instr[19:15]);
                m_op2 = (instr[14:12] == 3'd1) ? 32'(instr[24:20]) : imm;
            end
            7'h37: m_op2 = instr & 32'hFFFF_F000;
            7'h17: begin
                m_op1 = pc;
                m_op2 = instr & 32'hFFFF_F000;
            end
            default: begin
                m_we  = 1'b0;
                m_ill = 1'b1;
            end
        endcase
        if (m_rd == 5'd0) m_we = 1'b0;
    endtask

    // one clock: check in_ready, advance the model, take the edge, compare outputs
    task automatic cycle();
        logic rdy, acc;
        #1;
        rdy = !m_valid || out_ready;
        if (rst_n) check("in_ready", 32'(in_ready), 32'(rdy));
        acc = in_valid && rdy && !flush;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_valid = 1'b0; m_we = 1'b0; m_ill = 1'b0;
            m_opc = 5'd0; m_rd = 5'd0; m_op1 = 32'd0; m_op2 = 32'd0;
        end else begin
            if (acc) model_load();
            if (wb_en && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
            m_valid = flush ? 1'b0 : (acc ? 1'b1 : (m_valid && !out_ready));
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("alu_opc", 32'(alu_opc), 32'(m_opc));
        check("alu_op1", alu_op1, m_op1);
        check("alu_op2", alu_op2, m_op2);
        check("out_rd", 32'(out_rd), 32'(m_rd));
        check("out_we", 32'(out_we), 32'(m_we));
        check("out_illegal", 32'(out_illegal), 32'(m_ill));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        instr = 32'd0; pc = 32'd0; wb_data = 32'd0; wb_rd = 5'd0;
        m_valid = 1'b0;
        @(posedge clk); #1;
        cycle();
        cycle();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_op2", alu_op2, 32'd0);
        rst_n = 1'b1;

        // addi x1,x0,5
        in_valid = 1'b1; instr = 32'h0050_0093;
        cycle();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_op2", alu_op2, 32'd5);
        check("t1_rd", 32'(out_rd), 32'd1);
        check("t1_we", 32'(out_we), 32'd1);
        in_valid = 1'b0;
        cycle();

        // x2=7, x3=9, then sub x4,x2,x3
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
        cycle();
        wb_rd = 5'd3; wb_data = 32'd9;
        cycle();
        wb_en = 1'b0; in_valid = 1'b1; instr = 32'h4031_0233;
        cycle();
        check("t2_opc", 32'(alu_opc), 32'h10);
        check("t2_op1", alu_op1, 32'd7);
        check("t2_op2", alu_op2, 32'd9);

        // or x6,x5,x0 with x5 written in the same cycle
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_00AB; instr = 32'h0002_E333;
        cycle();
        check("t3_op1_bypass", alu_op1, 32'h0000_00AB);
        check("t3_opc", 32'(alu_opc), 32'h06);
        wb_en = 1'b0;

        // stall for three cycles with a waiting instruction
        instr = 32'h00A0_0413;
        cycle();
        out_ready = 1'b0; instr = 32'h0140_0493;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t4_hold_rd", 32'(out_rd), 32'd8);
            check("t4_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        check("t4_next_rd", 32'(out_rd), 32'd9);
        check("t4_next_op2", alu_op2, 32'd20);

        // flush while full, with a write-back aimed at x0
        flush = 1'b1; instr = 32'h0000_6533; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
        cycle();
        check("t5_flush_valid", 32'(out_valid), 32'd0);
        check("t5_flush_keep_rd", 32'(out_rd), 32'd9);
        flush = 1'b0; wb_en = 1'b0;
        cycle();
        check("t5_x0_op1", alu_op1, 32'd0);
        check("t5_x0_op2", alu_op2, 32'd0);

        // lui, illegal opcode, auipc, slli with high imm bits
        instr = 32'h1234_53B7;
        cycle();
        check("t6_lui_op2", alu_op2, 32'h1234_5000);
        instr = 32'h0000_007F;
        cycle();
        check("t6_illegal", 32'(out_illegal), 32'd1);
        check("t6_illegal_we", 32'(out_we), 32'd0);
        instr = 32'h0000_1297; pc = 32'h0000_0100;
        cycle();
        check("t6_auipc_op1", alu_op1, 32'h0000_0100);
        check("t6_auipc_op2", alu_op2, 32'h0000_1000);
        instr = 32'h4020_9093;
        cycle();
        check("t6_slli_op2", alu_op2, 32'd2);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 9) == 0);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_data   = $urandom;
            pc        = $urandom;
            instr     = $urandom;
            case ($urandom_range(0, 4))
                0: instr[6:0] = 7'h33;
                1: instr[6:0] = 7'h13;
                2: instr[6:0] = 7'h37;
                3: instr[6:0] = 7'h17;
                default: ;
            endcase
            wb_rd = ($urandom_range(0, 1) == 1) ? instr[19:15] : 5'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
